// File: rtl/pipe_pkg.sv
// Shared definitions for the ARM pipeline stage registers: control-bit indices,
// the default set of side-effecting control bits, and the control vector type.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF  = 8;
    localparam int unsigned CTRL_REG_WE = 0;
    localparam int unsigned CTRL_MEM_WE = 1;

    typedef logic [CTRL_W_DEF-1:0] ctrl_t;

    localparam ctrl_t KILL_MASK_DEF = ctrl_t'((1 << CTRL_REG_WE) | (1 << CTRL_MEM_WE));

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear beats a coincident increment, reset beats both.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with stall/flush, masked kill of side-effecting control
// bits in bubbles, and saturating stall/squash counters for performance debug.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W    = CTRL_W_DEF,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       RD_W      = 4,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(KILL_MASK_DEF),
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    logic stall_inc;
    logic squash_inc;

    assign stall_inc  = stall & ~flush;
    assign squash_inc = flush & valid_out;

    // Priority reset > flush > stall > load; bubbles never carry side-effecting bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            ctrl_out  <= '0;
            data_out  <= '0;
            rd_out    <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
            ctrl_out  <= ctrl_out & ~KILL_MASK;
        end else if (!stall) begin
            valid_out <= valid_in;
            ctrl_out  <= valid_in ? ctrl_in : (ctrl_in & ~KILL_MASK);
            data_out  <= data_in;
            rd_out    <= rd_in;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_squash_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (squash_inc),
        .clr   (cnt_clr),
        .count (squash_cnt)
    );

endmodule
